// File: rtl/alu_sequencer.sv
// Issue-side sequencer for the combinational ALU: buffers requests,
// drives registered ALU inputs, optionally reads flags, returns results.
module alu_sequencer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int TAGW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_cmd,
  input  logic [6:0]       req_opm,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_flags,
  input  logic [TAGW-1:0]  req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [WIDTH-1:0] rsp_flags,
  output logic [TAGW-1:0]  rsp_tag,
  output logic [6:0]       alu_opm,
  output logic [4:0]       alu_cmd,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [4:0] PASSFLAG = 5'b00010;

  typedef enum logic [1:0] {IDLE, EXEC, FLAG, RESP} state_t;

  typedef struct packed {
    logic [4:0]       cmd;
    logic [6:0]       opm;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flags;
    logic [TAGW-1:0]  tag;
  } entry_t;

  entry_t     mem [DEPTH];
  entry_t     head;
  logic [AW:0] wp;
  logic [AW:0] rp;
  logic        empty;
  logic        full;
  logic        push;
  logic        flag_req;
  state_t      state;

  assign empty     = (wp == rp);
  assign full      = ((wp - rp) == (AW+1)'(DEPTH));
  assign req_ready = !full;
  assign push      = req_valid && req_ready;
  assign head      = mem[rp[AW-1:0]];

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp[AW-1:0]] <= '{cmd: req_cmd, opm: req_opm, a: req_a,
                           b: req_b, flags: req_flags, tag: req_tag};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp         <= '0;
      rp         <= '0;
      state      <= IDLE;
      flag_req   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_tag    <= '0;
      alu_opm    <= '0;
      alu_cmd    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
    end else begin
      if (push) wp <= wp + (AW+1)'(1);
      unique case (state)
        IDLE: begin
          if (!empty) begin
            alu_opm  <= head.opm;
            alu_cmd  <= head.cmd;
            alu_a    <= head.a;
            alu_b    <= head.b;
            rsp_tag  <= head.tag;
            flag_req <= head.flags;
            rp       <= rp + (AW+1)'(1);
            state    <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_out;
          if (flag_req) begin
            alu_cmd <= PASSFLAG;
            state   <= FLAG;
          end else begin
            rsp_flags <= '0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        FLAG: begin
          rsp_flags <= alu_out;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a small behavioural ALU
// (combinational out, flag register updated on each clock edge).
module tb_alu_sequencer;

  localparam int W = 64;
  localparam logic [4:0] SIGN = 5'd1;
  localparam logic [4:0] PASS = 5'd2;
  localparam logic [4:0] INV  = 5'd4;
  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] FZ = 64'h800;
  localparam logic [W-1:0] FN = 64'h200;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [4:0]   req_cmd = '0;
  logic [6:0]   req_opm = '0;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         req_flags = 1'b0;
  logic [3:0]   req_tag = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] rsp_result;
  logic [W-1:0] rsp_flags;
  logic [3:0]   rsp_tag;
  logic [6:0]   alu_opm;
  logic [4:0]   alu_cmd;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_out;
  logic [W-1:0] flagreg = '0;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [W-1:0] r;
    logic [W-1:0] f;
    logic [3:0]   t;
  } exp_t;
  exp_t sb[$];

  alu_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_opm(req_opm),
    .req_a(req_a), .req_b(req_b),
    .req_flags(req_flags), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .rsp_tag(rsp_tag),
    .alu_opm(alu_opm), .alu_cmd(alu_cmd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: ZERO, SIGN, PASSFLAG, LOADFLAG, INV; others give 0.
  always_comb begin
    alu_out = '0;
    case (alu_cmd)
      SIGN:    alu_out = {W{alu_b[W-1]}};
      PASS:    alu_out = flagreg;
      INV:     alu_out = ~alu_a;
      default: alu_out = '0;
    endcase
  end

  always @(posedge clk) begin
    case (alu_cmd)
      5'd0: flagreg <= '0;
      SIGN: flagreg <= (alu_a == '0) ? FZ : '0;
      5'd3: flagreg <= alu_a;
      INV:  flagreg <= ((~alu_a == '0) ? FZ : '0) |
                       ((~alu_a) >> (W-1) != '0 ? FN : '0);
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp act_tag=%0d exp=none", rsp_tag);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_result", rsp_result, e.r);
        chk("rsp_flags", rsp_flags, e.f);
        chk("rsp_tag", W'(rsp_tag), W'(e.t));
      end
    end
  end

  task automatic send(input logic [4:0] cmd, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic fl,
                      input logic [3:0] tag, input bit track,
                      input logic [W-1:0] er, input logic [W-1:0] ef);
    bit ok;
    ok = 1'b0;
    if (track) sb.push_back('{r: er, f: ef, t: tag});
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_opm   = 7'h10 + 7'(tag);
    req_a     = a;
    req_b     = b;
    req_flags = fl;
    req_tag   = tag;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = req_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout act=0 exp=1 tag=%0d", tag);
    end
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout act=%0d exp=0", sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcnt;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_rsp_valid", W'(rsp_valid), 0);
    chk("rst_req_ready", W'(req_ready), 1);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_flags", rsp_flags, 0);
    chk("rst_rsp_tag", W'(rsp_tag), 0);
    repeat (10) @(posedge clk);
    #1;
    chk("idle_alu_a", alu_a, 0);
    chk("idle_alu_b", alu_b, 0);
    chk("idle_alu_cmd", W'(alu_cmd), 0);
    chk("idle_alu_opm", W'(alu_opm), 0);

    // Plain INV with latency check
    send(INV, 64'h0, 64'h0, 1'b0, 4'd3, 1'b1, ONES, 64'h0);
    @(posedge clk);
    #1;
    chk("lat1_valid", W'(rsp_valid), 0);
    chk("lat1_cmd", W'(alu_cmd), W'(INV));
    chk("lat1_opm", W'(alu_opm), 64'h13);
    @(posedge clk);
    #1;
    chk("lat2_valid", W'(rsp_valid), 1);
    drain();

    // INV with flags: Z, then N
    send(INV, ONES, 64'h0, 1'b1, 4'd1, 1'b1, 64'h0, FZ);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("flat2_valid", W'(rsp_valid), 0);
    @(posedge clk);
    #1;
    chk("flat3_valid", W'(rsp_valid), 1);
    drain();
    send(INV, 64'h0, 64'h0, 1'b1, 4'd2, 1'b1, ONES, FN);
    drain();

    // SIGN with flags, then a PASSFLAG request reading the flags back
    send(SIGN, 64'h0, 64'h8000_0000_0000_0000, 1'b1, 4'd6, 1'b1,
         ONES, FZ);
    drain();
    send(PASS, 64'h0, 64'h0, 1'b0, 4'd9, 1'b1, FZ, 64'h0);
    drain();

    // Backpressure: five accepted, sixth stalls until responses drain
    rsp_ready = 1'b0;
    for (int t = 0; t < 5; t++)
      send(INV, 64'(t), 64'h0, 1'b0, 4'(t), 1'b1, ~64'(t), 64'h0);
    chk("bp_full_ready", W'(req_ready), 0);
    fork
      send(INV, 64'd5, 64'h0, 1'b0, 4'd5, 1'b1, ~64'd5, 64'h0);
      begin
        repeat (6) @(posedge clk);
        #1 rsp_ready = 1'b1;
      end
    join
    drain();

    // Reset while in FLAG with two queued requests
    send(INV, 64'h0, 64'h0, 1'b1, 4'd10, 1'b0, 64'h0, 64'h0);
    send(INV, 64'h1, 64'h0, 1'b1, 4'd11, 1'b0, 64'h0, 64'h0);
    send(INV, 64'h2, 64'h0, 1'b1, 4'd12, 1'b0, 64'h0, 64'h0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mrst_valid", W'(rsp_valid), 0);
    chk("mrst_ready", W'(req_ready), 1);
    chk("mrst_alu_a", alu_a, 0);
    chk("mrst_alu_cmd", W'(alu_cmd), 0);
    vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) vcnt++;
    end
    chk("mrst_no_rsp", 64'(vcnt), 0);
    chk("mrst_alu_b", alu_b, 0);
    send(INV, 64'h0, 64'h0, 1'b1, 4'd7, 1'b1, ONES, FN);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
